// File: rtl/shift_pkg.sv
// Shared types for the shared barrel-shift datapath.
// Build option: SHIFT_ARB_FIXED_PRIO_EN (see shift_arbiter.sv).
package shift_pkg;

    localparam int SHIFT_DATA_W = 32;
    localparam int SHIFT_AMT_W  = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    typedef struct packed {
        logic [SHIFT_DATA_W-1:0] data;
        shift_type_e             typ;
        logic [SHIFT_AMT_W-1:0]  amt;
        logic                    cin;
    } shift_req_t;

endpackage

// File: rtl/shift_core.sv
// Combinational ARM register-controlled shifter: result and carry-out
// for LSL/LSR/ASR/ROR with an 8-bit amount.
module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_DATA_W-1:0] i_data,
    input  shift_type_e             i_type,
    input  logic [SHIFT_AMT_W-1:0]  i_amt,
    input  logic                    i_cin,
    output logic [SHIFT_DATA_W-1:0] o_result,
    output logic                    o_cout
);

    logic [4:0]              w_sh;
    logic                    w_ge32;
    logic                    w_is32;
    logic [SHIFT_DATA_W:0]   w_lsl;
    logic [SHIFT_DATA_W:0]   w_lsr;
    logic [SHIFT_DATA_W:0]   w_asr;
    logic [SHIFT_DATA_W-1:0] w_ror;

    assign w_sh   = i_amt[4:0];
    assign w_ge32 = |i_amt[7:5];
    assign w_is32 = (i_amt == 8'd32);

    // Extra bit on the far side of each shift catches the last bit shifted out.
    assign w_lsl = {1'b0, i_data} << w_sh;
    assign w_lsr = {i_data, 1'b0} >> w_sh;
    assign w_asr = $signed({i_data, 1'b0}) >>> w_sh;
    // w_sh==0 is handled separately, so the 32-bit left shift never matters.
    assign w_ror = (i_data >> w_sh) | (i_data << (6'd32 - {1'b0, w_sh}));

    // Select result/carry by type, with the a==0 passthrough taking precedence.
    always_comb begin
        o_result = i_data;
        o_cout   = i_cin;
        if (i_amt != '0) begin
            case (i_type)
                SH_LSL: begin
                    if (!w_ge32)     {o_cout, o_result} = w_lsl;
                    else if (w_is32) begin o_result = '0; o_cout = i_data[0]; end
                    else             begin o_result = '0; o_cout = 1'b0; end
                end
                SH_LSR: begin
                    if (!w_ge32)     {o_result, o_cout} = w_lsr;
                    else if (w_is32) begin o_result = '0; o_cout = i_data[31]; end
                    else             begin o_result = '0; o_cout = 1'b0; end
                end
                SH_ASR: begin
                    if (!w_ge32) {o_result, o_cout} = w_asr;
                    else begin
                        o_result = {SHIFT_DATA_W{i_data[31]}};
                        o_cout   = i_data[31];
                    end
                end
                default: begin
                    if (w_sh == 5'd0) begin
                        o_result = i_data;
                        o_cout   = i_data[31];
                    end else begin
                        o_result = w_ror;
                        o_cout   = w_ror[31];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of one shared barrel shifter, result held in a
// single registered slot with valid/ready.
// Build option: SHIFT_ARB_FIXED_PRIO_EN -> port 0 always wins a conflict
// (no round-robin pointer); default is round-robin.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][DATA_W-1:0]     req_data,
    input  logic [1:0][1:0]            req_type,
    input  logic [1:0][AMT_W-1:0]      req_amt,
    input  logic [1:0]                 req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_cout
);

    localparam logic S_EMPTY = 1'b0;
    localparam logic S_FULL  = 1'b1;

    logic              r_state;
    logic              r_id;
    logic [DATA_W-1:0] r_data;
    logic              r_cout;

    logic              w_slot_free;
    logic              w_grant;
    logic              w_sel;
    shift_req_t        w_req;
    logic [DATA_W-1:0] w_result;
    logic              w_cout;

    assign w_slot_free = (r_state == S_EMPTY) | rsp_ready;
    assign w_grant     = (|req_valid) & w_slot_free & !flush;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it asks; port 1 only when alone.
    assign w_sel = !req_valid[0];
`else
    logic r_last;
    logic w_both;

    assign w_both = &req_valid;
    assign w_sel  = w_both ? !r_last : req_valid[1];

    // Remember the most recent winner so the other port wins the next conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_last <= 1'b1;
        else if (w_grant) r_last <= w_sel;
    end
`endif

    // Ready is the grant itself; held low throughout reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = reset_n & w_grant & (w_sel == 1'(gi));
        end
    endgenerate

    // Grant mux: only the winning request reaches the shifter.
    always_comb begin
        w_req.data = req_data[w_sel];
        w_req.typ  = shift_type_e'(req_type[w_sel]);
        w_req.amt  = req_amt[w_sel];
        w_req.cin  = req_cin[w_sel];
    end

    shift_core u_core (
        .i_data   (w_req.data),
        .i_type   (w_req.typ),
        .i_amt    (w_req.amt),
        .i_cin    (w_req.cin),
        .o_result (w_result),
        .o_cout   (w_cout)
    );

    // Slot FSM: flush beats everything, a grant refills, a lone accept drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
            r_id    <= 1'b0;
            r_data  <= '0;
            r_cout  <= 1'b0;
        end else if (flush) begin
            r_state <= S_EMPTY;
        end else if (w_grant) begin
            r_state <= S_FULL;
            r_id    <= w_sel;
            r_data  <= w_result;
            r_cout  <= w_cout;
        end else if (rsp_ready) begin
            r_state <= S_EMPTY;
        end
    end

    assign rsp_valid = r_state;
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign rsp_cout  = r_cout;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table, hand sequences for the
// handshake corners, then a randomized run against a behavioural model.
module tb_shift_arbiter;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_data;
    logic [1:0][1:0]  req_type;
    logic [1:0][7:0]  req_amt;
    logic [1:0]       req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic             rsp_cout;

    int n_checks = 0;
    int n_fail   = 0;

    shift_arbiter #(.DATA_W(32), .AMT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_type(req_type), .req_amt(req_amt),
        .req_cin(req_cin), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference shifter written from the ARM rules, bit by bit.
    function automatic void ref_shift(input logic [31:0] d, input logic [1:0] t,
                                      input logic [7:0] a, input logic cin,
                                      output logic [31:0] r, output logic c);
        logic [63:0] v;
        int          n, idx;
        r = d; c = cin;
        if (a == 0) return;
        case (t)
            2'b00: begin v = {32'b0, d} << a; r = v[31:0];  c = v[32]; end
            2'b01: begin v = {d, 32'b0} >> a; r = v[63:32]; c = v[31]; end
            2'b10: begin
                for (int i = 0; i < 32; i++) begin
                    idx = i + int'(a);
                    if (idx > 31) idx = 31;
                    r[i] = d[idx];
                end
                idx = int'(a) - 1;
                if (idx > 31) idx = 31;
                c = d[idx];
            end
            default: begin
                n = int'(a) % 32;
                r = d;
                for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
                c = (n == 0) ? d[31] : r[31];
            end
        endcase
    endfunction

    typedef struct {
        int          port;
        logic [1:0]  typ;
        logic [31:0] d;
        logic [7:0]  a;
        logic        cin;
        logic [31:0] ed;
        logic        ec;
    } vec_t;

    vec_t tbl[14];

    task automatic set_port(input int p, input logic [1:0] t, input logic [31:0] d,
                            input logic [7:0] a, input logic cin);
        req_type[p] = t; req_data[p] = d; req_amt[p] = a; req_cin[p] = cin;
    endtask

    // Behavioural model state for the randomized phase
    logic        m_valid, m_id, m_cout, m_last;
    logic [31:0] m_data;

    logic [1:0] exp_ids [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 2'b00, 32'h0000_0001,   8'd31, 1'b0, 32'h8000_0000, 1'b0};
        tbl[1]  = '{1, 2'b01, 32'h8000_0000,   8'd32, 1'b0, 32'h0000_0000, 1'b1};
        tbl[2]  = '{1, 2'b10, 32'h8000_0000,   8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1};
        tbl[3]  = '{0, 2'b11, 32'h0000_0001,   8'd32, 1'b1, 32'h0000_0001, 1'b0};
        tbl[4]  = '{0, 2'b11, 32'h0000_0001,   8'd33, 1'b0, 32'h8000_0000, 1'b1};
        tbl[5]  = '{0, 2'b00, 32'hDEAD_BEEF,   8'd0,  1'b1, 32'hDEAD_BEEF, 1'b1};
        tbl[6]  = '{1, 2'b10, 32'h1234_5678,   8'd0,  1'b1, 32'h1234_5678, 1'b1};
        tbl[7]  = '{0, 2'b00, 32'h0000_0001,   8'd32, 1'b0, 32'h0000_0000, 1'b1};
        tbl[8]  = '{1, 2'b00, 32'hFFFF_FFFF,   8'd33, 1'b1, 32'h0000_0000, 1'b0};
        tbl[9]  = '{0, 2'b01, 32'h0000_00F0,   8'd4,  1'b1, 32'h0000_000F, 1'b0};
        tbl[10] = '{1, 2'b10, 32'h8000_0001,   8'd1,  1'b0, 32'hC000_0000, 1'b1};
        tbl[11] = '{0, 2'b11, 32'h1234_5678,   8'd4,  1'b0, 32'h8123_4567, 1'b1};
        tbl[12] = '{1, 2'b01, 32'hFFFF_FFFF,   8'd200,1'b1, 32'h0000_0000, 1'b0};
        tbl[13] = '{0, 2'b10, 32'h4000_0000,   8'd31, 1'b0, 32'h0000_0000, 1'b1};

`ifdef SHIFT_ARB_FIXED_PRIO_EN
        exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif

        reset_n = 1'b0; flush = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req_data = '0; req_type = '0; req_amt = '0; req_cin = '0;

        // Reset state, with requests pending
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data",  rsp_data, 32'd0);
        chk("reset_rsp_id",    32'(rsp_id), 32'd0);
        chk("reset_rsp_cout",  32'(rsp_cout), 32'd0);

        // Conflict sequence straight out of reset
        @(negedge clk);
        reset_n = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
        set_port(0, 2'b00, 32'h1, 8'd1, 1'b0);
        set_port(1, 2'b00, 32'h1, 8'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr_valid_%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("rr_id_%0d", k), 32'(rsp_id), 32'(exp_ids[k]));
        end
        req_valid = 2'b00;

        // Directed shift vectors, one request at a time
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_port(tbl[i].port, tbl[i].typ, tbl[i].d, tbl[i].a, tbl[i].cin);
            req_valid = 2'(1 << tbl[i].port);
            rsp_ready = 1'b1;
            #1 chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << tbl[i].port));
            @(negedge clk);
            req_valid = 2'b00;
            chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(tbl[i].port));
            chk($sformatf("vec%0d_data", i), rsp_data, tbl[i].ed);
            chk($sformatf("vec%0d_cout", i), 32'(rsp_cout), 32'(tbl[i].ec));
        end

        // Backpressure: slot full, consumer stalled for 3 cycles
        @(negedge clk);
        set_port(0, 2'b00, 32'h1, 8'd4, 1'b0);
        req_valid = 2'b01; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 2'b11;
        set_port(0, 2'b01, 32'hFFFF_0000, 8'd3, 1'b0);
        set_port(1, 2'b11, 32'hABCD_1234, 8'd7, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp_data_%0d", k), rsp_data, 32'h0000_0010);
            chk($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end

        // Flush together with rsp_ready: no grant, slot empties
        flush = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
        #1 chk("flush_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 2'b00;
        chk("flush_valid", 32'(rsp_valid), 32'd0);

        // Asynchronous reset while the slot is full
        @(negedge clk);
        set_port(1, 2'b00, 32'hFFFF_FFFF, 8'd1, 1'b0);
        req_valid = 2'b10; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 1'b0;
        chk("ar_pre_valid", 32'(rsp_valid), 32'd1);
        chk("ar_pre_id", 32'(rsp_id), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_data", rsp_data, 32'd0);
        chk("ar_id", 32'(rsp_id), 32'd0);
        chk("ar_cout", 32'(rsp_cout), 32'd0);
        req_valid = 2'b11;
        #1 chk("ar_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; req_valid = 2'b00;

        // Randomized traffic against the model
        m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_cout = 1'b0; m_last = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [1:0]  exp_rdy;
            logic        free, win;
            logic [31:0] r;
            logic        c;
            for (int p = 0; p < 2; p++) begin
                logic [7:0] a;
                case ($urandom_range(0, 3))
                    0: a = 8'($urandom_range(0, 255));
                    1: a = 8'($urandom_range(0, 40));
                    2: begin
                        case ($urandom_range(0, 4))
                            0: a = 8'd0;  1: a = 8'd31; 2: a = 8'd32;
                            3: a = 8'd33; default: a = 8'd64;
                        endcase
                    end
                    default: a = 8'($urandom_range(1, 31));
                endcase
                set_port(p, 2'($urandom_range(0, 3)), $urandom, a, 1'($urandom_range(0, 1)));
            end
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            // Winner: a lone requester, otherwise the arbitration rule
            if (req_valid == 2'b01)      win = 1'b0;
            else if (req_valid == 2'b10) win = 1'b1;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            else                         win = 1'b0;
`else
            else                         win = (m_last == 1'b0);
`endif
            free    = !m_valid || rsp_ready;
            exp_rdy = 2'b00;
            if (req_valid != 2'b00 && free && !flush) exp_rdy[win] = 1'b1;
            chk($sformatf("rnd%0d_ready", cyc), 32'(req_ready), 32'(exp_rdy));
            if (flush) m_valid = 1'b0;
            else if (exp_rdy != 2'b00) begin
                ref_shift(req_data[win], req_type[win], req_amt[win], req_cin[win], r, c);
                m_valid = 1'b1; m_id = win; m_data = r; m_cout = c; m_last = win;
            end else if (rsp_ready) m_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("rnd%0d_valid", cyc), 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk($sformatf("rnd%0d_data", cyc), rsp_data, m_data);
                chk($sformatf("rnd%0d_id", cyc), 32'(rsp_id), 32'(m_id));
                chk($sformatf("rnd%0d_cout", cyc), 32'(rsp_cout), 32'(m_cout));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
